// File: rtl/qar_exec_datapath.sv
// QAR-Core execute datapath: 32x32 register file (1 sync write, 2 async reads)
// plus a combinational RV32I integer ALU.
module qar_exec_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  input  logic [4:0]  rf_raddr1,
  input  logic [4:0]  rf_raddr2,
  output logic [31:0] rf_rdata1,
  output logic [31:0] rf_rdata2,
  input  logic [31:0] alu_op_a,
  input  logic [31:0] alu_op_b,
  input  logic [3:0]  alu_op,
  output logic [31:0] alu_result
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned SHW  = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  logic [XLEN-1:0] regs [NREG];
  logic [SHW-1:0]  shamt;

  // Register file: x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Reads see the pre-edge value; no write bypass keeps the read->ALU->write loop open.
  always_comb begin
    rf_rdata1 = (rf_raddr1 == 5'd0) ? '0 : regs[rf_raddr1];
    rf_rdata2 = (rf_raddr2 == 5'd0) ? '0 : regs[rf_raddr2];
  end

  assign shamt = alu_op_b[SHW-1:0];

  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = alu_op_a + alu_op_b;
      OP_SUB:  alu_result = alu_op_a - alu_op_b;
      OP_AND:  alu_result = alu_op_a & alu_op_b;
      OP_OR:   alu_result = alu_op_a | alu_op_b;
      OP_XOR:  alu_result = alu_op_a ^ alu_op_b;
      OP_SLL:  alu_result = alu_op_a << shamt;
      OP_SRL:  alu_result = alu_op_a >> shamt;
      OP_SRA:  alu_result = XLEN'($signed(alu_op_a) >>> shamt);
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(alu_op_a) < $signed(alu_op_b))};
      OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, (alu_op_a < alu_op_b)};
      default: alu_result = '0;
    endcase
  end

endmodule

// File: tb/tb_qar_exec_datapath.sv
// Scoreboard bench for qar_exec_datapath: driver queues expected outputs from a
// behavioural model, monitor compares them against the DUT on each sample event.
module tb_qar_exec_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;

  // loopback routes read data into the ALU and the ALU result into the write port
  logic        loopback;
  logic [31:0] a_drv, b_drv, wd_drv;

  assign alu_op_a = loopback ? rf_rdata1  : a_drv;
  assign alu_op_b = loopback ? rf_rdata2  : b_drv;
  assign rf_wdata = loopback ? alu_result : wd_drv;

  qar_exec_datapath dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .alu_op_a   (alu_op_a),
    .alu_op_b   (alu_op_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;   // 0: rf_rdata1, 1: rf_rdata2, 2: alu_result
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_rf [32];
  event        sample_ev;

  function automatic logic [31:0] model_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : model_rf[idx];
  endfunction

  // Reference ALU written from the operation definitions, not the RTL structure.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    int unsigned s;
    logic [31:0] r;
    s = int'(b % 32);
    case (op)
      4'd0: r = a + b;
      4'd1: r = a + (~b) + 32'd1;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << s;
      4'd6: r = a >> s;
      4'd7: begin
        r = a >> s;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
      end
      4'd8: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic void push(input string name, input int kind, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endfunction

  // Monitor: drains every queued expectation when the driver signals a stable sample point.
  initial begin
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.kind)
          0:       act = rf_rdata1;
          1:       act = rf_rdata2;
          default: act = alu_result;
        endcase
        vectors++;
        if (act !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  // One cycle: drive at posedge+1, check at negedge, update the model at the edge.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic use_exp, input logic [31:0] exp_alu, input string tag);
    logic [31:0] ea, eb, ealu, ewd;
    rf_we = we; rf_waddr = wa; wd_drv = wd;
    rf_raddr1 = r1; rf_raddr2 = r2;
    a_drv = a; b_drv = b; alu_op = op;
    #1;
    ea   = loopback ? model_rd(r1) : a;
    eb   = loopback ? model_rd(r2) : b;
    ealu = use_exp ? exp_alu : ref_alu(ea, eb, op);
    ewd  = loopback ? ealu : wd;
    push({tag, "_rd1"}, 0, model_rd(r1));
    push({tag, "_rd2"}, 1, model_rd(r2));
    push({tag, "_alu"}, 2, ealu);
    @(negedge clk);
    -> sample_ev;
    @(posedge clk);
    if (we && (wa != 5'd0) && rst_n) model_rf[wa] = ewd;
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
    string       name;
  } alu_vec_t;

  alu_vec_t dir_vecs [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] specials [6];
    logic [31:0] ra, rb;
    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF; specials[5] = 32'h1F;

    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    loopback = 1'b0;
    rst_n = 1'b0; rf_we = 1'b0; rf_waddr = '0; wd_drv = '0;
    rf_raddr1 = '0; rf_raddr2 = '0; a_drv = '0; b_drv = '0; alu_op = '0;

    // Reset state: reads return zero while held
    repeat (2) @(posedge clk);
    #1;
    step(1'b0, 5'd0, 32'd0, 5'd7, 5'd31, 32'd0, 32'd0, 4'd0, 1'b1, 32'd0, "reset_state");
    rst_n = 1'b1;

    // x0 hardwiring
    step(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "x0_wr");
    step(1'b1, 5'd1, 32'h1234_5678, 5'd0, 5'd1, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "x0_rd");
    step(1'b0, 5'd0, 32'd0, 5'd0, 5'd1, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "x1_rd");

    // Write timing, no bypass, write enable low
    step(1'b1, 5'd3, 32'd5, 5'd3, 5'd3, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "x3_w5");
    step(1'b1, 5'd3, 32'd7, 5'd3, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "x3_rdw");
    step(1'b0, 5'd3, 32'd9, 5'd3, 5'd3, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "x3_we0");
    step(1'b0, 5'd3, 32'd9, 5'd3, 5'd3, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "x3_hold");

    // Directed ALU vectors with hand-derived results
    dir_vecs.push_back('{32'hFFFF_FFFF, 32'd1,         4'd0,  32'd0,         "add_wrap"});
    dir_vecs.push_back('{32'd0,         32'd1,         4'd1,  32'hFFFF_FFFF, "sub_wrap"});
    dir_vecs.push_back('{32'd5,         32'hFFFF_FFFD, 4'd0,  32'd2,         "add_neg"});
    dir_vecs.push_back('{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2,  32'hF000_F000, "and"});
    dir_vecs.push_back('{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd3,  32'hFFF0_FFF0, "or"});
    dir_vecs.push_back('{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd4,  32'h0FF0_0FF0, "xor"});
    dir_vecs.push_back('{32'd1,         32'h21,        4'd5,  32'd2,         "sll"});
    dir_vecs.push_back('{32'h8000_0000, 32'd31,        4'd6,  32'd1,         "srl"});
    dir_vecs.push_back('{32'h8000_0000, 32'd4,         4'd7,  32'hF800_0000, "sra"});
    dir_vecs.push_back('{32'hFFFF_FFFF, 32'd1,         4'd8,  32'd1,         "slt"});
    dir_vecs.push_back('{32'hFFFF_FFFF, 32'd1,         4'd9,  32'd0,         "sltu"});
    dir_vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'd0,         "op_unused"});
    foreach (dir_vecs[i])
      step(1'b0, 5'd0, 32'd0, 5'd3, 5'd1, dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].op,
           1'b1, dir_vecs[i].exp, dir_vecs[i].name);

    // Write-back loop: x3 := x1 + x2 through the combinational read->ALU->write path
    step(1'b1, 5'd1, 32'd3, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "wb_x1");
    step(1'b1, 5'd2, 32'd4, 5'd0, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "wb_x2");
    loopback = 1'b1;
    step(1'b1, 5'd3, 32'd0, 5'd1, 5'd2, 32'd0, 32'd0, 4'd0, 1'b1, 32'd7, "wb_add");
    loopback = 1'b0;
    step(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "wb_x3");

    // Randomized traffic, some of it through the loopback path
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
      loopback = ($urandom_range(0, 4) == 0);
      step(1'($urandom_range(0, 1)), 5'($urandom), 32'($urandom), 5'($urandom), 5'($urandom),
           ra, rb, 4'($urandom), 1'b0, 32'd0, "rand");
    end
    loopback = 1'b0;

    // Async reset between edges clears everything; a write during reset is discarded
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "rst_pre");
    rf_we = 1'b0; rf_raddr1 = 5'd5; rf_raddr2 = 5'd3;
    #1;
    push("rst_before", 0, model_rd(5'd5));
    -> sample_ev;
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    #1;
    push("rst_async_rd1", 0, 32'd0);
    push("rst_async_rd2", 1, 32'd0);
    -> sample_ev;
    step(1'b1, 5'd5, 32'h0BAD_F00D, 5'd5, 5'd5, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "rst_wr");
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd3, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, "rst_after");

    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qar_exec_datapath.md
# qar_exec_datapath

Execute datapath for the QAR-Core RV32I core: a 32×32-bit integer register file and a combinational 32-bit ALU in one block. The core's decode logic drives the read addresses and the ALU operands/opcode, and writes the ALU result back through the register-file write port. There is one synchronous write port, two asynchronous read ports and a purely combinational ALU path.

## Interface
- XLEN, 32 — datapath width; fixed at 32, and all widths below assume it.
- clk  in  1  — single clock; all register-file writes occur on its rising edge.
- rst_n  in  1  — asynchronous, active-low reset; clears the register file.
- rf_we  in  1  — write enable for the register file.
- rf_waddr  in  5  — write register index.
- rf_wdata  in  32  — write data.
- rf_raddr1  in  5  — read port 1 index.
- rf_raddr2  in  5  — read port 2 index.
- rf_rdata1  out  32  — read port 1 data (combinational).
- rf_rdata2  out  32  — read port 2 data (combinational).
- alu_op_a  in  32  — ALU operand A.
- alu_op_b  in  32  — ALU operand B.
- alu_op  in  4  — ALU operation select.
- alu_result  out  32  — ALU result (combinational).

## Operation
- **Register file storage:** registers x0..x31, 32 bits each.
- **x0:** reads always return 0. Writes with rf_waddr=0 are discarded.
- **Write:**
  - On a rising edge with rst_n=1 and rf_we=1 and rf_waddr≠0, the register rf_waddr takes rf_wdata.
  - With rf_we=0, no register changes.
- **Reads:**
  - rf_rdataN = reg[rf_raddrN], or 0 when rf_raddrN=0.
  - Both ports are fully independent and may address the same register.
- **ALU encodings** (op_a, op_b unsigned 32-bit; results truncated modulo 2^32):
  - 0000 ADD: a+b, carry discarded.
  - 0001 SUB: a−b, two's complement, wraps.
  - 0010 AND: a&b.
  - 0011 OR: a|b.
  - 0100 XOR: a^b.
  - 0101 SLL: a << b[4:0]. b[31:5] is ignored.
  - 0110 SRL: a >> b[4:0], logical (zero fill).
  - 0111 SRA: a >>> b[4:0], arithmetic (sign fill from a[31]).
  - 1000 SLT: {31'b0, signed(a) < signed(b)}.
  - 1001 SLTU: {31'b0, a < b unsigned}.
  - 1010–1111: result 0.
- The ALU has no state and no dependency on clk or rst_n.

## Timing
- **Reset:**
  - Assertion of rst_n=0 immediately clears all 32 registers to 0, independent of clk.
  - While reset is held, rf_rdata1 and rf_rdata2 read 0.
  - A write presented during reset is discarded.
  - Reset asserted mid-operation overrides any pending write on the same edge.
- **Output reset values:**
  - rf_rdata1 and rf_rdata2 are 0.
  - alu_result is not registered; it always equals f(alu_op_a, alu_op_b, alu_op).
- **Write latency:** 1 cycle. Data written at edge N is visible on the read ports after edge N.
- **Read-during-write to the same register in the same cycle:**
  - The read port returns the old value; there is no write-to-read bypass.
  - This allows rf_wdata to be derived combinationally from rf_rdata without a loop.
- **ALU and read latency:** zero cycles; both paths are combinational.
- The read → ALU → rf_wdata path must close in one cycle.

## Test plan
- **Reset:**
  - Stimulus: write 0xDEADBEEF to x5, then pulse rst_n low between clock edges.
  - Required: rf_rdata1(raddr1=5) = 0 immediately, before any clk edge.
- **x0 hardwiring:**
  - Stimulus: rf_we=1, waddr=0, wdata=0x12345678, one edge.
  - Required: raddr1=0 → 0.
  - Stimulus: write 0x12345678 to x1.
  - Required: raddr2=1 → 0x12345678.
- **Write/read timing and no bypass:**
  - Stimulus: x3=5, then on the next cycle write x3 := 7 with raddr1=3.
  - Required: rdata1 = 5 before the edge, 7 after it.
  - Stimulus: rf_we=0 with wdata=9.
  - Required: x3 stays 7.
- **ADD/SUB wrap:**
  - ADD: a=0xFFFFFFFF, b=1 → 0.
  - SUB: a=0, b=1 → 0xFFFFFFFF.
  - ADD: a=5, b=0xFFFFFFFD (−3) → 2.
- **Logic and shifts:**
  - AND 0xF0F0F0F0, 0xFF00FF00 → 0xF000F000.
  - OR of the same operands → 0xFFF0FFF0.
  - XOR of the same operands → 0x0FF00FF0.
  - SLL: a=1, b=0x21 → 2 (only b[4:0] is used).
  - SRL: a=0x80000000, b=31 → 1.
  - SRA: a=0x80000000, b=4 → 0xF8000000.
- **Compares and unused opcodes:**
  - SLT: a=0xFFFFFFFF, b=1 → 1.
  - SLTU with the same operands → 0.
  - Opcode 1111 → 0.
  - Write-back loop: x1=3, x2=4, ADD result written to x3 → x3 reads 7 next cycle.
